// File: rtl/fifo_rd_fwft.sv
// rtl/fifo_rd_fwft.sv - first-word-fall-through read side with 3-entry output buffer
module fifo_rd_fwft #(
    parameter int DATASIZE = 8
) (
    input  logic                i_rd_clk,
    input  logic                i_rd_rst_n,
    input  logic                i_empty,
    input  logic [DATASIZE-1:0] i_mem_rdata,
    input  logic                i_ready,
    input  logic                i_flush,
    output logic                o_rd_en,
    output logic                o_valid,
    output logic [DATASIZE-1:0] o_data,
    output logic [1:0]          o_level
);

    logic [DATASIZE-1:0] buf_q [0:2];
    logic [1:0]          wr_idx;
    logic [1:0]          rd_idx;
    logic [1:0]          buf_cnt;
    logic                inflight;
    logic                push;
    logic                pop;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Credit check counts the word already in flight so the buffer can never overflow.
    assign o_rd_en = i_rd_rst_n && !i_empty && !i_flush &&
                     (({1'b0, buf_cnt} + {2'b00, inflight}) < 3'd3);

    assign push = inflight && !i_flush;
    assign pop  = (buf_cnt != 2'd0) && i_ready && !i_flush;

    always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
        if (!i_rd_rst_n) begin
            wr_idx   <= 2'd0;
            rd_idx   <= 2'd0;
            buf_cnt  <= 2'd0;
            inflight <= 1'b0;
        end else if (i_flush) begin
            wr_idx   <= 2'd0;
            rd_idx   <= 2'd0;
            buf_cnt  <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= o_rd_en;
            if (push) begin
                wr_idx <= next_idx(wr_idx);
            end
            if (pop) begin
                rd_idx <= next_idx(rd_idx);
            end
            case ({push, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    // Data storage carries no reset; contents are only observed while o_valid is high.
    always_ff @(posedge i_rd_clk) begin
        if (push) begin
            buf_q[wr_idx] <= i_mem_rdata;
        end
    end

    assign o_valid = (buf_cnt != 2'd0);
    assign o_level = buf_cnt;
    assign o_data  = buf_q[rd_idx];

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// tb/tb_fifo_rd_fwft.sv - randomized and directed bench with a queue-based FWFT model
module tb_fifo_rd_fwft;

    logic       clk;
    logic       i_rd_rst_n;
    logic       i_empty;
    logic [7:0] i_mem_rdata;
    logic       i_ready;
    logic       i_flush;
    logic       o_rd_en;
    logic       o_valid;
    logic [7:0] o_data;
    logic [1:0] o_level;

    fifo_rd_fwft #(.DATASIZE(8)) dut (
        .i_rd_clk    (clk),
        .i_rd_rst_n  (i_rd_rst_n),
        .i_empty     (i_empty),
        .i_mem_rdata (i_mem_rdata),
        .i_ready     (i_ready),
        .i_flush     (i_flush),
        .o_rd_en     (o_rd_en),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_level     (o_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;

    logic [7:0] q[$];
    bit         pending = 0;
    logic [7:0] ret_word = 8'h00;
    logic [7:0] src_next = 8'h00;
    bit         exp_rd_en;

    logic       obs_rd_en;
    logic       obs_valid;
    logic [7:0] obs_data;
    logic [1:0] obs_level;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // One read-clock cycle: drive, compare against the model, then advance the model at the edge.
    task automatic step(input logic e, input logic r, input logic f);
        @(negedge clk);
        cyc++;
        i_rd_rst_n  = 1'b1;
        i_empty     = e;
        i_ready     = r;
        i_flush     = f;
        i_mem_rdata = pending ? ret_word : 8'($urandom);
        #1;
        exp_rd_en = !e && !f && ((q.size() + int'(pending)) < 3);
        obs_rd_en = o_rd_en;
        obs_valid = o_valid;
        obs_data  = o_data;
        obs_level = o_level;
        chk("rd_en", 32'(o_rd_en), 32'(exp_rd_en));
        chk("valid", 32'(o_valid), 32'(q.size() != 0));
        chk("level", 32'(o_level), 32'(q.size()));
        if (q.size() != 0) chk("data", 32'(o_data), 32'(q[0]));
        @(posedge clk);
        if (f) begin
            q.delete();
            pending = 0;
        end else begin
            if (q.size() != 0 && r) void'(q.pop_front());
            if (pending) q.push_back(ret_word);
            pending = exp_rd_en;
            if (exp_rd_en) begin
                ret_word = src_next;
                src_next = src_next + 8'd1;
            end
        end
    endtask

    // Reset asserted mid-cycle; held across the following edge, released by the next step.
    task automatic reset_pulse();
        @(negedge clk);
        cyc++;
        i_empty     = 1'b0;
        i_ready     = 1'b1;
        i_flush     = 1'b0;
        i_mem_rdata = pending ? ret_word : 8'($urandom);
        #2;
        i_rd_rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_rd_en", 32'(o_rd_en), 32'd0);
        q.delete();
        pending = 0;
        @(posedge clk);
    endtask

    logic [7:0] resume_word;

    initial begin
        i_rd_rst_n  = 1'b0;
        i_empty     = 1'b0;
        i_ready     = 1'b0;
        i_flush     = 1'b0;
        i_mem_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("init_valid", 32'(o_valid), 32'd0);
        chk("init_level", 32'(o_level), 32'd0);
        chk("init_rd_en", 32'(o_rd_en), 32'd0);

        // Idle after release with nothing to read
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("idle_valid", 32'(obs_valid), 32'd0);
            chk("idle_rd_en", 32'(obs_rd_en), 32'd0);
        end

        // Single word 0xA5
        src_next = 8'hA5;
        step(1'b0, 1'b1, 1'b0);
        chk("single_rd_en0", 32'(obs_rd_en), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("single_valid1", 32'(obs_valid), 32'd0);
        chk("single_rd_en1", 32'(obs_rd_en), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("single_valid2", 32'(obs_valid), 32'd1);
        chk("single_data2", 32'(obs_data), 32'hA5);
        step(1'b1, 1'b1, 1'b0);
        chk("single_valid3", 32'(obs_valid), 32'd0);

        // Back-to-back stream 0x01..0x10
        src_next = 8'h01;
        for (int k = 0; k < 20; k++) begin
            step(src_next == 8'h11, 1'b1, 1'b0);
            if (k >= 2 && k <= 17) begin
                chk("stream_valid", 32'(obs_valid), 32'd1);
                chk("stream_data", 32'(obs_data), 32'(k - 1));
            end
            if (k == 18) chk("stream_end", 32'(obs_valid), 32'd0);
        end

        // Backpressure to full, then drain across the index wrap
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        src_next = 8'h20;
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0);
        chk("full_level", 32'(obs_level), 32'd3);
        chk("full_rd_en", 32'(obs_rd_en), 32'd0);
        chk("full_data", 32'(obs_data), 32'h20);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("drain_data", 32'(obs_data), 32'(8'h20 + k));
        end
        step(1'b1, 1'b1, 1'b0);
        chk("drain_done", 32'(obs_valid), 32'd0);

        // Flush with two buffered words and one in flight
        src_next = 8'h40;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("flush_pre_level", 32'(obs_level), 32'd2);
        chk("flush_rd_en", 32'(obs_rd_en), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("flush_level", 32'(obs_level), 32'd0);
        chk("flush_valid", 32'(obs_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("flush_nopush", 32'(obs_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("flush_next_data", 32'(obs_data), 32'h43);
        step(1'b1, 1'b1, 1'b0);

        // Reset pulse mid-stream, stream resumes from the current source word
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0);
        reset_pulse();
        resume_word = src_next;
        step(1'b0, 1'b1, 1'b0);
        chk("resume_rd_en", 32'(obs_rd_en), 32'd1);
        chk("resume_valid0", 32'(obs_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("resume_valid1", 32'(obs_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("resume_data", 32'(obs_data), 32'(resume_word));

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_pulse();
            end else begin
                step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 99) < 3);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_rd_fwft.md
FIFO_RD_FWFT -- requirements
Module: fifo_rd_fwft

Interface
REQ-001 Parameter DATASIZE, default 8, width of the FIFO data word.
REQ-002 i_rd_clk  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 i_rd_rst_n  input  1  read-domain reset, asynchronous, active-low.
REQ-004 i_empty  input  1  registered empty flag from the read-pointer/empty-flag stage.
REQ-005 i_mem_rdata  input  DATASIZE  FIFO memory read data, registered read, 1-cycle latency.
REQ-006 i_ready  input  1  downstream consumer accepts the current word.
REQ-007 i_flush  input  1  synchronous discard of all buffered and in-flight words.
REQ-008 o_rd_en  output  1  read enable to the read-pointer/empty-flag stage.
REQ-009 o_valid  output  1  o_data holds a valid word.
REQ-010 o_data  output  DATASIZE  head-of-buffer word, first-word-fall-through.
REQ-011 o_level  output  2  number of words held in the output buffer, 0..3.

Function
REQ-012 Memory contract: o_rd_en high in cycle N with i_empty low pops one word; that word is on i_mem_rdata in cycle N+1 and SHALL be captured at the end of cycle N+1.
REQ-013 The block SHALL hold a 3-entry circular output buffer, 2-bit write and read indices wrapping 2->0, and an occupancy count buf_cnt of 0..3.
REQ-014 A 1-bit register inflight SHALL equal the previous cycle's o_rd_en.
REQ-015 o_rd_en SHALL equal !i_empty && !i_flush && (buf_cnt + inflight < 3), using registered state and inputs only, with no dependence on i_ready.
REQ-016 Push: when inflight=1 and i_flush=0, i_mem_rdata SHALL be written to buf[wr_idx] and wr_idx SHALL advance.
REQ-017 Pop: when o_valid && i_ready && !i_flush, rd_idx SHALL advance.
REQ-018 buf_cnt SHALL change by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-019 o_valid SHALL equal (buf_cnt != 0), o_data SHALL equal buf[rd_idx], and o_level SHALL equal buf_cnt; all are driven from registers only.
REQ-020 o_data SHALL stay stable while o_valid && !i_ready.
REQ-021 Overflow SHALL be impossible by construction: the credit rule of REQ-015 guarantees buf_cnt + inflight <= 3.
REQ-022 Latency: the first word after i_empty falls with the buffer empty SHALL appear with o_valid high 2 cycles after the first cycle o_rd_en is high.
REQ-023 Throughput: with i_ready held high and i_empty low, the block SHALL sustain one word per cycle after fill.
REQ-024 Flush: in a cycle with i_flush=1, the block SHALL force o_rd_en=0, ignore push and pop, and at the clock edge clear buf_cnt, wr_idx, rd_idx and inflight to 0.
REQ-025 A word returning from a pop issued in the cycle before the flush SHALL be discarded; FIFO pointers are not rewound, and the popped words are lost by design.
REQ-026 Simultaneous i_flush and i_ready: the flush takes priority and no pop is counted.
REQ-027 i_empty going high while inflight=1 SHALL still push the in-flight word.

Reset
REQ-028 Asserting i_rd_rst_n low SHALL immediately set buf_cnt=0, wr_idx=0, rd_idx=0 and inflight=0, giving o_valid=0, o_level=0 and o_rd_en=0.
REQ-029 Buffer data registers need not be reset; o_data is don't-care while o_valid=0.
REQ-030 Reset asserted mid-transfer SHALL drop all buffered and in-flight words, and no push SHALL occur on the first edge after release.
REQ-031 After release, o_rd_en SHALL assert in the first cycle where i_empty=0.

Verification
REQ-032 Reset release, i_empty=1 -> o_valid=0, o_level=0 and o_rd_en=0 for 10 cycles.
REQ-033 Single word 0xA5, i_empty low for 1 cycle, i_ready=1 -> o_rd_en pulses once, o_valid=1 with o_data=0xA5 exactly 2 cycles later for 1 cycle.
REQ-034 Stream 0x01..0x10, i_empty=0, i_ready=1 -> after a 2-cycle fill, o_valid is continuous for 16 cycles and data arrives in order.
REQ-035 i_ready=0 with FIFO non-empty -> o_level reaches 3, o_rd_en=0, and o_data stays at the first word; i_ready=1 then drains 3 words in order across index wrap.
REQ-036 i_flush asserted with o_level=2 and inflight=1 -> the next cycle shows o_level=0 and o_valid=0, and the returned word is not pushed.
REQ-037 i_rd_rst_n pulsed low mid-stream -> all outputs return to 0 asynchronously, and the stream resumes from the current FIFO word after release.
